// File: rtl/prim_clock_gate_ctrl_pkg.sv
// prim_clock_gate_ctrl_pkg: shared state encoding and widths for the clock-gate enable controller
package prim_clock_gate_ctrl_pkg;
  typedef enum logic [1:0] {StOn, StIdleCnt, StOff, StWake} state_e;
  localparam int CntWidth    = 8;
  localparam int StatsGatedW = 32;
  localparam int StatsWakeW  = 16;
endpackage

// File: rtl/prim_clock_gate_ctrl.sv
// prim_clock_gate_ctrl: idle-driven clock-gate enable with four-phase wake handshake; optional stats via PRIM_CLOCK_GATE_CTRL_STATS_EN
//   clk_i, rst_ni (async active-low), idle_i, wake_req_i, force_on_i -> en_o, wake_ack_o, gated_o
//   stats build adds gated_cycles_o (cycles with en_o=0) and wake_count_o (StOff->StWake exits)
module prim_clock_gate_ctrl
  import prim_clock_gate_ctrl_pkg::*;
#(
  parameter int IdleCycles = 16,
  parameter int WakeCycles = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic idle_i,
  input  logic wake_req_i,
  input  logic force_on_i,
  output logic en_o,
  output logic wake_ack_o,
  output logic gated_o
`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
  ,
  output logic [StatsGatedW-1:0] gated_cycles_o,
  output logic [StatsWakeW-1:0]  wake_count_o
`endif
);
  if (IdleCycles < 1 || IdleCycles > 255) begin : g_bad_idle
    $error("IdleCycles out of range 1..255");
  end
  if (WakeCycles < 1 || WakeCycles > 255) begin : g_bad_wake
    $error("WakeCycles out of range 1..255");
  end
  state_e r_state, w_state_d;
  logic [CntWidth-1:0] r_cnt, w_cnt_d;
  logic r_en, r_ack, r_gated;
  logic w_hold, w_idle_end, w_wake_end;
  always_comb begin
    w_hold     = idle_i & ~wake_req_i & ~force_on_i;
    w_idle_end = r_cnt == CntWidth'(IdleCycles - 1);
    w_wake_end = r_cnt == CntWidth'(WakeCycles - 1);
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    case (r_state)
      StOn: begin
        w_state_d = w_hold ? StIdleCnt : StOn;
        w_cnt_d   = '0;
      end
      StIdleCnt: begin
        w_state_d = !w_hold ? StOn : w_idle_end ? StOff : StIdleCnt;
        w_cnt_d   = (w_hold && !w_idle_end) ? r_cnt + 1'b1 : '0;
      end
      StOff: begin
        w_state_d = w_hold ? StOff : StWake;
        w_cnt_d   = '0;
      end
      default: begin
        w_state_d = w_wake_end ? StOn : StWake;
        w_cnt_d   = w_wake_end ? '0 : r_cnt + 1'b1;
      end
    endcase
  end
  // outputs are registered from the next state so they line up with r_state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StOn;
      r_cnt   <= '0;
      r_en    <= 1'b1;
      r_ack   <= 1'b0;
      r_gated <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_en    <= w_state_d != StOff;
      r_gated <= w_state_d == StOff;
      r_ack   <= wake_req_i & (r_state inside {StOn, StIdleCnt}) & (w_state_d != StOff);
    end
  end
  assign en_o       = r_en;
  assign wake_ack_o = r_ack;
  assign gated_o    = r_gated;
`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
  logic [StatsGatedW-1:0] r_gated_cycles;
  logic [StatsWakeW-1:0]  r_wake_count;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_gated_cycles <= '0;
      r_wake_count   <= '0;
    end else begin
      if (!r_en && !(&r_gated_cycles)) r_gated_cycles <= r_gated_cycles + 1'b1;
      if (r_state == StOff && w_state_d == StWake && !(&r_wake_count)) r_wake_count <= r_wake_count + 1'b1;
    end
  end
  assign gated_cycles_o = r_gated_cycles;
  assign wake_count_o   = r_wake_count;
`endif
endmodule

// File: tb/tb_prim_clock_gate_ctrl.sv
// tb_prim_clock_gate_ctrl: directed self-checking bench for prim_clock_gate_ctrl (IdleCycles=4, WakeCycles=2)
module tb_prim_clock_gate_ctrl;
  logic clk = 1'b0;
  logic rst_ni, idle_i, wake_req_i, force_on_i;
  logic en_o, wake_ack_o, gated_o;
  int n_chk = 0;
  int n_pass = 0;
`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
  logic [31:0] gated_cycles_o;
  logic [15:0] wake_count_o;
`endif
  always #5 clk = ~clk;
  prim_clock_gate_ctrl #(.IdleCycles(4), .WakeCycles(2)) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .idle_i(idle_i),
    .wake_req_i(wake_req_i),
    .force_on_i(force_on_i),
    .en_o(en_o),
    .wake_ack_o(wake_ack_o),
    .gated_o(gated_o)
`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
    ,
    .gated_cycles_o(gated_cycles_o),
    .wake_count_o(wake_count_o)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  initial begin
    rst_ni = 1'b0; idle_i = 1'b0; wake_req_i = 1'b0; force_on_i = 1'b0;
    tick(); tick();
    chk("rst_en", en_o, 1); chk("rst_ack", wake_ack_o, 0); chk("rst_gated", gated_o, 0);
    rst_ni = 1'b1;
    tick();
    idle_i = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); chk("t1_en_hi", en_o, 1); end
    tick();
    chk("t1_en_lo", en_o, 0); chk("t1_gated", gated_o, 1);
    tick();
    chk("t1_stay_gated", gated_o, 1);
    wake_req_i = 1'b1;
    tick(); chk("t2_en_up", en_o, 1); chk("t2_ungated", gated_o, 0); chk("t2_ack0a", wake_ack_o, 0);
    tick(); chk("t2_ack0b", wake_ack_o, 0);
    tick(); chk("t2_ack0c", wake_ack_o, 0);
    tick(); chk("t2_ack1", wake_ack_o, 1);
    wake_req_i = 1'b0;
    tick(); chk("t2_ack_drop", wake_ack_o, 0); chk("t2_en", en_o, 1);
    idle_i = 1'b0;
    tick();
    idle_i = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); chk("t3_en_cnt", en_o, 1); end
    idle_i = 1'b0;
    tick(); chk("t3_en_abort", en_o, 1);
    tick(); chk("t3_en_abort2", en_o, 1);
    idle_i = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); chk("t3_en_fresh", en_o, 1); end
    tick(); chk("t3_en_lo", en_o, 0);
    wake_req_i = 1'b1;
    repeat (4) tick();
    chk("t3_wake_ack", wake_ack_o, 1);
    wake_req_i = 1'b0; idle_i = 1'b0;
    tick(); tick();
    idle_i = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); chk("t4_en_cnt", en_o, 1); end
    wake_req_i = 1'b1;
    tick(); chk("t4_en_kept", en_o, 1); chk("t4_ack", wake_ack_o, 1);
    tick(); chk("t4_en_kept2", en_o, 1); chk("t4_ack2", wake_ack_o, 1);
    wake_req_i = 1'b0; idle_i = 1'b0;
    tick(); chk("t4_ack_drop", wake_ack_o, 0);
    force_on_i = 1'b1; idle_i = 1'b1;
    for (int i = 0; i < 100; i++) begin tick(); chk("t5_force_en", en_o, 1); end
    force_on_i = 1'b0;
    repeat (5) tick();
    chk("t5_gated", gated_o, 1); chk("t5_en_lo", en_o, 0);
    #2 rst_ni = 1'b0;
    #1 chk("t5_async_en", en_o, 1); chk("t5_async_gated", gated_o, 0);
    tick();
    rst_ni = 1'b1; idle_i = 1'b0;
    tick();
`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
    chk("t6_gc_rst", gated_cycles_o, 0); chk("t6_wc_rst", wake_count_o, 0);
    for (int r = 0; r < 3; r++) begin
      idle_i = 1'b1;
      repeat (5) tick();
      chk("t6_en_lo", en_o, 0);
      repeat (9) tick();
      wake_req_i = 1'b1;
      repeat (4) tick();
      chk("t6_ack", wake_ack_o, 1);
      wake_req_i = 1'b0; idle_i = 1'b0;
      tick();
    end
    chk("t6_gated_cycles", gated_cycles_o, 30); chk("t6_wake_count", wake_count_o, 3);
`endif
    idle_i = 1'b1;
    repeat (5) tick();
    chk("t7_gated", gated_o, 1);
    force_on_i = 1'b1;
    tick(); chk("t7_force_wake_en", en_o, 1); chk("t7_force_wake_gated", gated_o, 0);
    tick(); tick(); chk("t7_force_on_en", en_o, 1); chk("t7_no_ack", wake_ack_o, 0);
    force_on_i = 1'b0; idle_i = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
